// File: rtl/mdu_e.sv
// mdu_e: E-stage multiply/divide unit holding the architectural HI/LO pair.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-high; clears HI/LO, shadow, counter, busy
//   MDU_Start     E-stage instruction is a valid MDU op this cycle
//   MDU_Op        0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   MDU_A         forwarded rs value
//   MDU_B         forwarded rt value
//   MDU_RSel      read select: 01 HI, 10 LO, otherwise 0
//   MDU_Out       combinational read of committed HI/LO
//   MDU_Busy      registered; high while a mult/div is in flight
//   MDU_Stall_Src MDU_Busy, or a mult/div starting this cycle
//
// A mult/div computes its result in a single cycle into shadow registers at
// the start edge; a down-counter then models the latency and the shadow is
// copied into HI/LO on the edge where the counter reaches zero.

module mdu_e #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MDU_Start,
  input  logic [2:0]  MDU_Op,
  input  logic [31:0] MDU_A,
  input  logic [31:0] MDU_B,
  input  logic [1:0]  MDU_RSel,
  output logic [31:0] MDU_Out,
  output logic        MDU_Busy,
  output logic        MDU_Stall_Src
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  logic [31:0] hi_r, lo_r, shadow_hi_r, shadow_lo_r;
  logic [3:0]  count_r;
  logic        busy_r;

  logic [31:0] hi_next_s, lo_next_s, shadow_hi_next_s, shadow_lo_next_s;
  logic [3:0]  count_next_s;
  logic        busy_next_s;

  logic        mul_signed_s, div_signed_s;
  logic [63:0] a_ext_s, b_ext_s, product_s;
  logic        a_neg_s, b_neg_s;
  logic [31:0] a_mag_s, b_mag_s, divisor_s;
  logic [31:0] quot_mag_s, rem_mag_s, quot_s, rem_s;
  logic        is_muldiv_s;

  // Datapath: product and quotient/remainder of the current operands.
  always_comb begin
    mul_signed_s = (MDU_Op == OP_MULT);
    div_signed_s = (MDU_Op == OP_DIV);
    // A 64-bit unsigned product of sign-extended operands equals the signed
    // product modulo 2^64, so one multiplier serves both flavours.
    a_ext_s   = mul_signed_s ? {{32{MDU_A[31]}}, MDU_A} : {32'd0, MDU_A};
    b_ext_s   = mul_signed_s ? {{32{MDU_B[31]}}, MDU_B} : {32'd0, MDU_B};
    product_s = a_ext_s * b_ext_s;
    // Signed divide on magnitudes: quotient truncates toward zero and the
    // remainder follows the dividend's sign. 0x80000000 / -1 yields
    // quotient 0x80000000, remainder 0.
    a_neg_s    = div_signed_s & MDU_A[31];
    b_neg_s    = div_signed_s & MDU_B[31];
    a_mag_s    = a_neg_s ? (32'd0 - MDU_A) : MDU_A;
    b_mag_s    = b_neg_s ? (32'd0 - MDU_B) : MDU_B;
    // Divide-by-zero result is discarded; keep the divider well defined.
    divisor_s  = (b_mag_s == 32'd0) ? 32'd1 : b_mag_s;
    quot_mag_s = a_mag_s / divisor_s;
    rem_mag_s  = a_mag_s % divisor_s;
    quot_s     = (a_neg_s ^ b_neg_s) ? (32'd0 - quot_mag_s) : quot_mag_s;
    rem_s      = a_neg_s ? (32'd0 - rem_mag_s) : rem_mag_s;
  end

  // State register: counter (IDLE when zero), busy flag, HI/LO and shadow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_r        <= 32'd0;
      lo_r        <= 32'd0;
      shadow_hi_r <= 32'd0;
      shadow_lo_r <= 32'd0;
      count_r     <= 4'd0;
      busy_r      <= 1'b0;
    end else begin
      hi_r        <= hi_next_s;
      lo_r        <= lo_next_s;
      shadow_hi_r <= shadow_hi_next_s;
      shadow_lo_r <= shadow_lo_next_s;
      count_r     <= count_next_s;
      busy_r      <= busy_next_s;
    end
  end

  // Next-state logic: start ops only when IDLE, count down and commit when BUSY.
  always_comb begin
    hi_next_s        = hi_r;
    lo_next_s        = lo_r;
    shadow_hi_next_s = shadow_hi_r;
    shadow_lo_next_s = shadow_lo_r;
    count_next_s     = count_r;
    if (count_r != 4'd0) begin
      // Any start while busy is dropped entirely.
      count_next_s = count_r - 4'd1;
      if (count_r == 4'd1) begin
        hi_next_s = shadow_hi_r;
        lo_next_s = shadow_lo_r;
      end else begin
        hi_next_s = hi_r;
      end
    end else if (MDU_Start) begin
      case (MDU_Op)
        OP_MULT, OP_MULTU: begin
          shadow_hi_next_s = product_s[63:32];
          shadow_lo_next_s = product_s[31:0];
          count_next_s     = MULT_CNT;
        end
        OP_DIV, OP_DIVU: begin
          if (MDU_B == 32'd0) begin
            shadow_hi_next_s = hi_r;
            shadow_lo_next_s = lo_r;
          end else begin
            shadow_hi_next_s = rem_s;
            shadow_lo_next_s = quot_s;
          end
          count_next_s = DIV_CNT;
        end
        OP_MTHI: hi_next_s = MDU_A;
        OP_MTLO: lo_next_s = MDU_A;
        default: count_next_s = count_r;
      endcase
    end else begin
      count_next_s = count_r;
    end
    busy_next_s = (count_next_s != 4'd0);
  end

  // Outputs: HI/LO read mux and stall source.
  always_comb begin
    is_muldiv_s = (MDU_Op == OP_MULT) || (MDU_Op == OP_MULTU) ||
                  (MDU_Op == OP_DIV)  || (MDU_Op == OP_DIVU);
    case (MDU_RSel)
      2'b01:   MDU_Out = hi_r;
      2'b10:   MDU_Out = lo_r;
      default: MDU_Out = 32'd0;
    endcase
    MDU_Busy      = busy_r;
    MDU_Stall_Src = busy_r | (MDU_Start & is_muldiv_s);
  end

endmodule

// File: tb/tb_mdu_e.sv
module tb_mdu_e;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MDU_Start = 1'b0;
  logic [2:0]  MDU_Op = 3'd0;
  logic [31:0] MDU_A = 32'd0;
  logic [31:0] MDU_B = 32'd0;
  logic [1:0]  MDU_RSel = 2'd0;
  logic [31:0] MDU_Out;
  logic        MDU_Busy;
  logic        MDU_Stall_Src;

  int nvec  = 0;
  int nfail = 0;
  bit chk_en = 1'b0;

  // Reference model: HI/LO, result waiting to commit, and the edge index at
  // which it commits. Busy means the current edge index is below that mark.
  logic [31:0] hi_m = 32'd0, lo_m = 32'd0, res_hi = 32'd0, res_lo = 32'd0;
  int ek = 0;
  int done_edge = -1;

  mdu_e #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .MDU_Start(MDU_Start), .MDU_Op(MDU_Op),
    .MDU_A(MDU_A), .MDU_B(MDU_B), .MDU_RSel(MDU_RSel), .MDU_Out(MDU_Out),
    .MDU_Busy(MDU_Busy), .MDU_Stall_Src(MDU_Stall_Src)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    longint p, q, r;
    longint unsigned pu;
    ek++;
    if (reset) begin
      hi_m = 32'd0; lo_m = 32'd0; res_hi = 32'd0; res_lo = 32'd0; done_edge = -1;
    end else if (ek <= done_edge) begin
      if (ek == done_edge) begin
        hi_m = res_hi; lo_m = res_lo;
      end
    end else if (MDU_Start) begin
      case (MDU_Op)
        3'd1: begin
          p = longint'($signed(MDU_A)) * longint'($signed(MDU_B));
          res_hi = p[63:32]; res_lo = p[31:0]; done_edge = ek + MULT_N;
        end
        3'd2: begin
          pu = {32'd0, MDU_A} * {32'd0, MDU_B};
          res_hi = pu[63:32]; res_lo = pu[31:0]; done_edge = ek + MULT_N;
        end
        3'd3, 3'd4: begin
          if (MDU_B == 32'd0) begin
            res_hi = hi_m; res_lo = lo_m;
          end else if (MDU_Op == 3'd3) begin
            q = longint'($signed(MDU_A)) / longint'($signed(MDU_B));
            r = longint'($signed(MDU_A)) % longint'($signed(MDU_B));
            res_hi = r[31:0]; res_lo = q[31:0];
          end else begin
            res_hi = MDU_A % MDU_B; res_lo = MDU_A / MDU_B;
          end
          done_edge = ek + DIV_N;
        end
        3'd5: hi_m = MDU_A;
        3'd6: lo_m = MDU_A;
        default: ;
      endcase
    end
  endtask

  // Every cycle, compare all outputs against the model, away from the edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic busy_m;
      logic [31:0] out_m;
      busy_m = (ek < done_edge);
      out_m = (MDU_RSel == 2'b01) ? hi_m : (MDU_RSel == 2'b10) ? lo_m : 32'd0;
      check("busy", {31'd0, MDU_Busy}, {31'd0, busy_m});
      check("stall_src", {31'd0, MDU_Stall_Src},
            {31'd0, busy_m | (MDU_Start & (MDU_Op >= 3'd1) & (MDU_Op <= 3'd4))});
      check("out", MDU_Out, out_m);
    end
  end

  task automatic tick(input logic st, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [1:0] rs);
    MDU_Start = st; MDU_Op = op; MDU_A = a; MDU_B = b; MDU_RSel = rs;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    tick(1'b0, 3'd0, 32'd0, 32'd0, 2'd0);
  endtask

  task automatic peek(input string name, input logic [1:0] rs, input logic [31:0] exp);
    MDU_Start = 1'b0; MDU_RSel = rs;
    #1;
    check(name, MDU_Out, exp);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (MDU_Busy && n < 30) begin
      idle();
      n++;
    end
    if (n >= 30) check("busy_timeout", {31'd0, MDU_Busy}, 32'd0);
  endtask

  initial begin
    int n;
    logic [2:0] rop;
    // Reset and idle read-back.
    idle(); idle();
    chk_en = 1'b1;
    reset = 1'b0;
    idle();
    peek("rst_hi", 2'b01, 32'd0);
    peek("rst_lo", 2'b10, 32'd0);
    check("rst_busy", {31'd0, MDU_Busy}, 32'd0);

    // mult -2 * 3 with HI preset to 5, busy for exactly 5 cycles.
    tick(1'b1, 3'd5, 32'd5, 32'd0, 2'd0);
    tick(1'b1, 3'd1, 32'hFFFFFFFE, 32'd3, 2'd0);
    for (int i = 1; i <= MULT_N; i++) begin
      check("mult_busy", {31'd0, MDU_Busy}, 32'd1);
      peek("mult_old_hi", 2'b01, 32'd5);
      idle();
    end
    check("mult_done", {31'd0, MDU_Busy}, 32'd0);
    peek("mult_hi", 2'b01, 32'hFFFFFFFF);
    peek("mult_lo", 2'b10, 32'hFFFFFFFA);

    // multu, stall source high in the start cycle.
    MDU_Start = 1'b1; MDU_Op = 3'd2; MDU_A = 32'hFFFFFFFE; MDU_B = 32'd3;
    #1;
    check("multu_stall_start", {31'd0, MDU_Stall_Src}, 32'd1);
    tick(1'b1, 3'd2, 32'hFFFFFFFE, 32'd3, 2'd0);
    wait_idle(n);
    check("multu_cycles", n, MULT_N);
    peek("multu_hi", 2'b01, 32'd2);
    peek("multu_lo", 2'b10, 32'hFFFFFFFA);

    // Signed and unsigned divide.
    tick(1'b1, 3'd3, 32'hFFFFFFF9, 32'd2, 2'd0);
    wait_idle(n);
    check("div_cycles", n, DIV_N);
    peek("div_lo", 2'b10, 32'hFFFFFFFD);
    peek("div_hi", 2'b01, 32'hFFFFFFFF);
    tick(1'b1, 3'd4, 32'd7, 32'd2, 2'd0);
    wait_idle(n);
    peek("divu_lo", 2'b10, 32'd3);
    peek("divu_hi", 2'b01, 32'd1);

    // Divide by zero leaves HI/LO alone but still occupies the unit.
    tick(1'b1, 3'd5, 32'h12345678, 32'd0, 2'd0);
    tick(1'b1, 3'd3, 32'd5, 32'd0, 2'd0);
    wait_idle(n);
    check("div0_cycles", n, DIV_N);
    peek("div0_hi", 2'b01, 32'h12345678);
    peek("div0_lo", 2'b10, 32'd3);

    // Starts during a running mult are dropped (no write, no reload).
    tick(1'b1, 3'd1, 32'd7, 32'd6, 2'd0);
    idle(); idle();
    tick(1'b1, 3'd6, 32'hDEADBEEF, 32'd0, 2'd0);
    tick(1'b1, 3'd1, 32'd100, 32'd100, 2'd0);
    wait_idle(n);
    check("viol_cycles", n + 4, MULT_N);
    peek("viol_lo", 2'b10, 32'h0000002A);
    peek("viol_hi", 2'b01, 32'd0);

    // Asynchronous reset with the counter at 3.
    tick(1'b1, 3'd4, 32'd100, 32'd3, 2'd0);
    for (int i = 0; i < DIV_N - 3; i++) idle();
    check("pre_reset_busy", {31'd0, MDU_Busy}, 32'd1);
    #1 reset = 1'b1;
    hi_m = 32'd0; lo_m = 32'd0; done_edge = -1;
    #1;
    check("async_rst_busy", {31'd0, MDU_Busy}, 32'd0);
    peek("async_rst_hi", 2'b01, 32'd0);
    peek("async_rst_lo", 2'b10, 32'd0);
    idle();
    reset = 1'b0;
    idle();

    // Randomised traffic, including occasional starts while busy.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a, b;
      rop = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = 32'($urandom_range(1, 9));
        3:       b = 32'hFFFFFFFF;
        default: b = 32'($urandom);
      endcase
      if (i == 300) begin
        a = 32'h80000000; b = 32'hFFFFFFFF; rop = 3'd3;
      end
      tick(($urandom_range(0, 2) == 0) || (i == 300), rop, a, b, 2'($urandom_range(0, 3)));
    end
    wait_idle(n);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
